// File: rtl/ifu_fetch.sv
// Instruction fetch unit: holds the architectural PC, fetches one word per
// req/ready handshake, presents it to decode and advances to npc_in on consume.
module ifu_fetch #(
  parameter logic [31:0] PC_RESET = 32'h0000_3000,
  parameter int          IM_WORDS = 4096
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] npc_in,
  input  logic        advance,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [31:0] pc,
  output logic [31:0] pc_plus_4,
  output logic [31:0] instr,
  output logic        instr_valid,
  output logic        fetch_err,
  output logic [31:0] fetch_count
);

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_WAIT  = 2'd1,
    S_HOLD  = 2'd2,
    S_ERR   = 2'd3
  } state_t;

  localparam logic [31:0] LP_SPAN = 32'(IM_WORDS) << 2;

  state_t      r_state;
  logic [31:0] r_pc;
  logic [31:0] r_instr;
  logic        r_valid;
  logic        r_err;
  logic [31:0] r_count;

  logic [31:0] w_npc_off;
  logic        w_npc_legal;

  // Offset from PC_RESET; targets below PC_RESET wrap to huge values and fail.
  assign w_npc_off   = npc_in - PC_RESET;
  assign w_npc_legal = (npc_in[1:0] == 2'b00) && (w_npc_off < LP_SPAN);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_FETCH;
      r_pc    <= PC_RESET;
      r_instr <= '0;
      r_valid <= 1'b0;
      r_err   <= 1'b0;
      r_count <= '0;
    end else begin
      case (r_state)
        S_FETCH: r_state <= S_WAIT;
        S_WAIT: begin
          if (imem_ready) begin
            r_instr <= imem_rdata;
            r_valid <= 1'b1;
            r_count <= r_count + 32'd1;
            r_state <= S_HOLD;
          end
        end
        S_HOLD: begin
          if (advance) begin
            r_valid <= 1'b0;
            if (w_npc_legal) begin
              r_pc    <= npc_in;
              r_state <= S_FETCH;
            end else begin
              r_err   <= 1'b1;
              r_state <= S_ERR;
            end
          end
        end
        default: r_state <= S_ERR;
      endcase
    end
  end

  // Request is a decode of the state register, suppressed while reset is held.
  assign imem_req    = (r_state == S_FETCH) && !reset;
  assign imem_addr   = r_pc;
  assign pc          = r_pc;
  assign pc_plus_4   = r_pc + 32'd4;
  assign instr       = r_instr;
  assign instr_valid = r_valid;
  assign fetch_err   = r_err;
  assign fetch_count = r_count;

endmodule

// File: tb/tb_ifu_fetch.sv
// Scoreboard bench for ifu_fetch: stimulus queues expected requests and
// deliveries; monitors pop and compare whenever the DUT presents them.
module tb_ifu_fetch;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] npc_in = '0;
  logic        advance = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic [31:0] pc;
  logic [31:0] pc_plus_4;
  logic [31:0] instr;
  logic        instr_valid;
  logic        fetch_err;
  logic [31:0] fetch_count;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] cnt;
  } deliv_t;

  logic [31:0] exp_req_q[$];
  deliv_t      exp_del_q[$];
  logic        prev_valid = 1'b0;

  ifu_fetch dut (
    .clk        (clk),
    .reset      (reset),
    .npc_in     (npc_in),
    .advance    (advance),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ready (imem_ready),
    .imem_rdata (imem_rdata),
    .pc         (pc),
    .pc_plus_4  (pc_plus_4),
    .instr      (instr),
    .instr_valid(instr_valid),
    .fetch_err  (fetch_err),
    .fetch_count(fetch_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end else begin
      $display("ok   %s: %08h", name, act);
    end
  endtask

  // Request monitor: every request pulse must match the next queued address.
  always @(negedge clk) begin
    if (!reset && imem_req) begin
      if (exp_req_q.size() == 0) begin
        check("unexpected_req", imem_addr, 32'hFFFF_FFFF);
      end else begin
        check("req_addr", imem_addr, exp_req_q.pop_front());
      end
    end
  end

  // Delivery monitor: each rising instr_valid is one delivered instruction.
  always @(negedge clk) begin
    if (instr_valid && !prev_valid) begin
      if (exp_del_q.size() == 0) begin
        check("unexpected_deliv", instr, 32'hFFFF_FFFF);
      end else begin
        deliv_t d;
        d = exp_del_q.pop_front();
        check("deliv_pc", pc, d.pc);
        check("deliv_instr", instr, d.instr);
        check("deliv_count", fetch_count, d.cnt);
      end
    end
    prev_valid <= instr_valid;
  end

  task automatic expect_fetch(input logic [31:0] a, input logic [31:0] data, input logic [31:0] cnt);
    deliv_t d;
    d.pc = a; d.instr = data; d.cnt = cnt;
    exp_req_q.push_back(a);
    exp_del_q.push_back(d);
  endtask

  task automatic do_reset();
    reset = 1'b1; advance = 1'b0; imem_ready = 1'b0;
    @(posedge clk); #1;
    check("rst_req", {31'd0, imem_req}, 32'd0);
    check("rst_pc", pc, 32'h3000);
    check("rst_valid", {31'd0, instr_valid}, 32'd0);
    check("rst_instr", instr, 32'd0);
    check("rst_err", {31'd0, fetch_err}, 32'd0);
    check("rst_count", fetch_count, 32'd0);
    reset = 1'b0;
  endtask

  // Wait for the request, then answer after 'delay' WAIT cycles.
  task automatic serve(input int delay, input logic [31:0] data, output int waited);
    bit seen = 0;
    waited = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (imem_req) seen = 1; else waited++;
    end
    if (!seen) begin
      check("req_timeout", 32'd0, 32'd1);
      return;
    end
    @(posedge clk); #1;
    for (int i = 0; i < delay; i++) begin
      @(negedge clk);
      check("wait_valid_low", {31'd0, instr_valid}, 32'd0);
      @(posedge clk); #1;
    end
    imem_ready = 1'b1; imem_rdata = data;
    @(posedge clk); #1;
    imem_ready = 1'b0; imem_rdata = 32'hA5A5_A5A5;
    @(negedge clk);
    check("latency_valid", {31'd0, instr_valid}, 32'd1);
  endtask

  task automatic advance_to(input logic [31:0] npc);
    @(posedge clk); #1;
    advance = 1'b1; npc_in = npc;
    @(posedge clk); #1;
    advance = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    // 1: first fetch after reset, minimum latency
    do_reset();
    expect_fetch(32'h3000, 32'h3C01_1234, 32'd1);
    serve(0, 32'h3C01_1234, w);

    // 2: sequential advance, slow memory
    expect_fetch(32'h3004, 32'h8C22_0004, 32'd2);
    advance_to(32'h3004);
    serve(3, 32'h8C22_0004, w);

    // 3: misaligned target -> ERR, no more requests, reset recovers
    advance_to(32'h3006);
    check("mis_err", {31'd0, fetch_err}, 32'd1);
    check("mis_pc", pc, 32'h3004);
    check("mis_valid", {31'd0, instr_valid}, 32'd0);
    repeat (5) @(negedge clk);
    check("err_sticky", {31'd0, fetch_err}, 32'd1);
    do_reset();

    // 4: range boundaries
    expect_fetch(32'h3000, 32'h1111_0000, 32'd1);
    serve(0, 32'h1111_0000, w);
    expect_fetch(32'h6FFC, 32'h2222_6FFC, 32'd2);
    advance_to(32'h6FFC);
    serve(1, 32'h2222_6FFC, w);
    check("top_err", {31'd0, fetch_err}, 32'd0);
    check("top_pc4", pc_plus_4, 32'h7000);
    advance_to(32'h7000);
    check("over_err", {31'd0, fetch_err}, 32'd1);
    check("over_pc", pc, 32'h6FFC);
    do_reset();
    expect_fetch(32'h3000, 32'h3333_0000, 32'd1);
    serve(0, 32'h3333_0000, w);
    advance_to(32'h2FFC);
    check("under_err", {31'd0, fetch_err}, 32'd1);
    check("under_pc", pc, 32'h3000);

    // 5: reset during WAIT with ready in the same cycle
    do_reset();
    exp_req_q.push_back(32'h3000);
    @(negedge clk);
    @(posedge clk); #1;
    reset = 1'b1; imem_ready = 1'b1; imem_rdata = 32'hBAD0_BAD0;
    @(posedge clk); #1;
    check("rw_valid", {31'd0, instr_valid}, 32'd0);
    check("rw_count", fetch_count, 32'd0);
    check("rw_pc", pc, 32'h3000);
    reset = 1'b0; imem_ready = 1'b0;
    expect_fetch(32'h3000, 32'h4444_0000, 32'd1);
    serve(0, 32'h4444_0000, w);
    check("rw_req_delay", w, 32'd0);

    // 6: advance ignored outside HOLD, ready ignored in HOLD, self-loop
    expect_fetch(32'h3008, 32'h5555_3008, 32'd2);
    advance_to(32'h3008);
    advance = 1'b1; npc_in = 32'h3100;
    serve(2, 32'h5555_3008, w);
    advance = 1'b0;
    check("ign_adv_pc", pc, 32'h3008);
    @(posedge clk); #1;
    imem_ready = 1'b1; imem_rdata = 32'hDEAD_BEEF;
    @(posedge clk); #1;
    imem_ready = 1'b0;
    @(negedge clk);
    check("hold_instr", instr, 32'h5555_3008);
    check("hold_valid", {31'd0, instr_valid}, 32'd1);
    check("hold_count", fetch_count, 32'd2);
    expect_fetch(32'h3008, 32'h6666_3008, 32'd3);
    advance_to(32'h3008);
    serve(0, 32'h6666_3008, w);
    check("self_err", {31'd0, fetch_err}, 32'd0);

    repeat (3) @(negedge clk);
    check("req_q_empty", exp_req_q.size(), 32'd0);
    check("del_q_empty", exp_del_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
